// File: rtl/imem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Data wins ties until MAX_DATA_RUN consecutive data grants have made fetch wait.
module imem_arbiter #(
    parameter int ADDR_WIDTH   = 9,
    parameter int WORD_WIDTH   = 32,
    parameter int MAX_DATA_RUN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_stall,
    output logic [WORD_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } own_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    own_t       own_q, own_d;
    logic [3:0] run_cnt_q, run_cnt_d;

    // Grants are suppressed during reset so no RAM access or store can slip out.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && (!i_req || (run_cnt_q < MAX_RUN))) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (i_gnt) begin
            run_cnt_d = 4'd0;
        end else if (d_gnt && i_req) begin
            run_cnt_d = (run_cnt_q < MAX_RUN) ? run_cnt_q + 4'd1 : MAX_RUN;
        end else if (!i_req && d_req) begin
            run_cnt_d = 4'd0;
        end
    end

    // Owner of the read word returning next cycle; stores return nothing.
    always_comb begin
        own_d = OWN_NONE;
        if (i_gnt) begin
            own_d = OWN_INST;
        end else if (d_gnt && !d_we) begin
            own_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q     <= OWN_NONE;
            run_cnt_q <= 4'd0;
        end else begin
            own_q     <= own_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign i_stall   = i_req & ~i_gnt;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_we    = d_gnt & d_we;
    assign mem_wdata = d_wdata;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_rvalid  = (own_q == OWN_INST);
    assign d_rvalid  = (own_q == OWN_DATA);

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a behavioural RAM, directed scenarios plus random traffic,
// and a scoreboard that pairs every issued read with its returned word.
module tb_imem_arbiter;

    localparam int AW  = 9;
    localparam int WW  = 32;
    localparam int MAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [WW-1:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_gnt, i_stall, i_rvalid, d_gnt, d_rvalid, mem_we;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [WW-1:0] ref_mem [0:(1<<AW)-1];
    logic [WW-1:0] exp_i_q [$];
    logic [WW-1:0] exp_d_q [$];
    int            wait_run = 0;

    // environment RAM
    logic [WW-1:0] ram [0:(1<<AW)-1];

    logic       last_i, last_d;
    logic [15:0] gpat;

    imem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_DATA_RUN(MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle when inputs and outputs are settled.
    always @(negedge clk) begin
        logic          e_i, e_d;
        logic [WW-1:0] e;
        // returned words from reads issued last cycle
        if (i_rvalid) begin
            if (exp_i_q.size() == 0) chk("i_rvalid_unexpected", 1, 0);
            else begin e = exp_i_q.pop_front(); chk("i_rdata", i_rdata, e); end
        end else if (exp_i_q.size() != 0) begin
            chk("i_rvalid_missing", 0, 1);
            void'(exp_i_q.pop_front());
        end
        if (d_rvalid) begin
            if (exp_d_q.size() == 0) chk("d_rvalid_unexpected", 1, 0);
            else begin e = exp_d_q.pop_front(); chk("d_rdata", d_rdata, e); end
        end else if (exp_d_q.size() != 0) begin
            chk("d_rvalid_missing", 0, 1);
            void'(exp_d_q.pop_front());
        end

        // who should own the RAM this cycle
        e_d = !rst && d_req && (!i_req || wait_run < MAX);
        e_i = !rst && i_req && !e_d;
        chk("d_gnt", d_gnt, e_d);
        chk("i_gnt", i_gnt, e_i);
        chk("i_stall", i_stall, i_req && !e_i);
        chk("mem_we", mem_we, e_d && d_we);
        chk("mem_addr", mem_addr, e_d ? d_addr : i_addr);
        if (e_d && d_we) chk("mem_wdata", mem_wdata, d_wdata);

        if (e_i) exp_i_q.push_back(ref_mem[i_addr]);
        if (e_d && !d_we) exp_d_q.push_back(ref_mem[d_addr]);
        if (e_d && d_we) ref_mem[d_addr] = d_wdata;

        // fetch-wait run length for the next cycle
        if (rst) wait_run = 0;
        else if (e_i) wait_run = 0;
        else if (e_d && i_req) wait_run = (wait_run < MAX) ? wait_run + 1 : MAX;
        else if (!i_req && d_req) wait_run = 0;
    end

    task automatic step();
        @(negedge clk);
        last_i = i_gnt;
        last_d = d_gnt;
        gpat   = {gpat[14:0], i_gnt};
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        rst = ($urandom_range(0, 49) == 0);
        if (!(i_req && !last_i)) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = AW'($urandom_range(0, 15));
        end
        if (!(d_req && !last_d)) begin
            d_req   = ($urandom_range(0, 1) != 0);
            d_we    = ($urandom_range(0, 1) != 0);
            d_addr  = AW'($urandom_range(0, 15));
            d_wdata = $urandom;
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = 32'hA5000000 + i;
            ref_mem[i] = 32'hA5000000 + i;
        end
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[9] = 32'hDEAD;
        ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33; ref_mem[9] = 32'hDEAD;

        rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        last_i = 0; last_d = 0; gpat = '0;
        @(posedge clk); #1;
        step(); step();
        rst = 0;
        step();

        // fetch only, consecutive addresses
        for (int a = 0; a < 3; a++) begin
            i_req = 1; i_addr = AW'(a);
            step();
            chk("fetch_only_gnt", last_i, 1);
        end
        i_req = 0;
        step();

        // load beats a waiting fetch
        i_req = 1; i_addr = 5; d_req = 1; d_we = 0; d_addr = 9;
        step();
        chk("load_prio_dgnt", last_d, 1);
        d_req = 0;
        step();
        chk("load_prio_fetch_next", last_i, 1);
        i_req = 0;
        step();

        // starvation bound with both sides always requesting
        i_req = 1; i_addr = 7; d_req = 1; d_we = 0; d_addr = 3;
        gpat = '0;
        for (int c = 0; c < 8; c++) step();
        chk("starve_pattern", WW'(gpat[7:0]), WW'(8'b0001_0001));
        i_req = 0; d_req = 0;
        step();

        // store and fetch to the same address
        i_req = 1; i_addr = 4; d_req = 1; d_we = 1; d_addr = 4; d_wdata = 32'hCAFE;
        step();
        chk("store_first", last_d, 1);
        d_req = 0; d_we = 0;
        step();
        chk("fetch_after_store", last_i, 1);
        i_req = 0;
        step();

        // reset right after a granted load
        d_req = 1; d_we = 0; d_addr = 9;
        step();
        rst = 1; d_req = 0; i_req = 1; i_addr = 2;
        step(); step();
        rst = 0; d_req = 1; d_addr = 1;
        gpat = '0;
        for (int c = 0; c < 4; c++) step();
        chk("post_reset_run_clear", WW'(gpat[3:0]), WW'(4'b0001));
        i_req = 0; d_req = 0;

        // idle
        for (int c = 0; c < 3; c++) step();

        // random traffic
        for (int c = 0; c < 600; c++) rand_cycle();
        rst = 0; i_req = 0; d_req = 0;
        step(); step(); step();

        chk("i_queue_drained", WW'(exp_i_q.size()), 0);
        chk("d_queue_drained", WW'(exp_d_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port synchronous word memory between the instruction-fetch requester and the load/store data requester.
- Data accesses have priority. A bounded-run counter stops fetch from being starved.
- Sits between the fetch stage, the memory stage and the block RAM.
- Drives the RAM address, write-enable and write-data. Routes the read word back to whichever requester issued the read one cycle earlier. Produces the fetch stall.

Parameters:
- ADDR_WIDTH, 9, RAM word-address width.
- WORD_WIDTH, 32, data word width.
- MAX_DATA_RUN, 3, maximum consecutive data grants while fetch waits. Legal range 1..15.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch requests a read this cycle.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch read issued to RAM this cycle.
- i_stall  out  1  i_req & ~i_gnt; the fetch stage holds pc/ir.
- i_rdata  out  WORD_WIDTH  instruction word.
- i_rvalid  out  1  i_rdata valid; asserted one cycle after i_gnt.
- d_req  in  1  data access request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  WORD_WIDTH  store data.
- d_gnt  out  1  data access issued to RAM this cycle.
- d_rdata  out  WORD_WIDTH  load data.
- d_rvalid  out  1  load data valid; asserted one cycle after a granted load only.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  WORD_WIDTH  RAM write data.
- mem_rdata  in  WORD_WIDTH  RAM read data, valid the cycle after the address.

Behaviour:
- **Grant logic** is combinational from the current-cycle inputs and `run_cnt`. At most one grant per cycle.
  - d_req only: d_gnt=1.
  - i_req only: i_gnt=1.
  - Both requesting and `run_cnt` < MAX_DATA_RUN: d_gnt=1.
  - Both requesting and `run_cnt` == MAX_DATA_RUN: i_gnt=1.
  - Neither requesting: no grant.
- **RAM drive**
  - mem_addr = d_addr when d_gnt, otherwise i_addr. It defaults to i_addr when idle.
  - mem_we = d_gnt & d_we.
  - mem_wdata = d_wdata at all times.
- **run_cnt** is a 4-bit register.
  - Increments, saturating at MAX_DATA_RUN, on each cycle with d_gnt & i_req.
  - Clears on any cycle with i_gnt, or with i_req low.
  - Holds when both requests are low.
- **Owner register `own_q`** has states NONE, INST and DATA.
  - Loads INST on i_gnt.
  - Loads DATA on d_gnt & ~d_we.
  - Loads NONE otherwise, including granted stores.
  - i_rvalid = (own_q == INST); d_rvalid = (own_q == DATA).
  - i_rdata = d_rdata = mem_rdata, unregistered. Consumers qualify with rvalid.
- **Latency:** a read granted in cycle N returns data in cycle N+1. A store commits at the cycle-N edge.
- **Back-to-back grants:** legal every cycle, with no bubble between requesters.
- **Reset:**
  - While rst=1: i_gnt=d_gnt=0, mem_we=0 and i_stall=i_req.
  - At the reset edge: `own_q` goes to NONE and `run_cnt` goes to 0.
  - In the cycle after reset deasserts, i_rvalid=d_rvalid=0.
  - A read granted in the cycle before rst rises still returns its rvalid in the next cycle, because `own_q` is sampled before reset takes effect. It then clears.
- **Requester contract:** requesters hold req/addr/wdata stable until granted. The arbiter does not queue requests.
- **Simultaneous store and fetch** at the same address: the store wins, and the fetch is granted a later cycle and reads the new value.

Test Plan:
- Fetch only: i_req=1, i_addr=0,1,2 on consecutive cycles, RAM preloaded with 0x11,0x22,0x33 -> i_gnt=1 every cycle; i_rvalid=1 from the second cycle with i_rdata=0x11,0x22,0x33; i_stall=0.
- Load priority: i_req=1 (addr 5), d_req=1, d_we=0, d_addr=9 (RAM[9]=0xDEAD) for one cycle -> d_gnt=1, i_stall=1, mem_addr=9; next cycle d_rvalid=1, d_rdata=0xDEAD, i_gnt=1, mem_addr=5.
- Starvation bound: MAX_DATA_RUN=3, i_req and d_req held high for 8 cycles -> grant pattern D,D,D,I,D,D,D,I.
- Store then fetch, same address: d_we=1, d_addr=4, d_wdata=0xCAFE with i_req=1, i_addr=4 -> mem_we=1 and no rvalid in the store cycle; fetch is granted next cycle; i_rdata=0xCAFE one cycle later.
- Reset mid-operation: load granted in cycle N, rst=1 in cycle N+1 -> d_rvalid=1 in N+1; all grants 0 and mem_we=0 while rst=1; `run_cnt` is 0 and no rvalid in the first cycle after release.
- Idle: i_req=d_req=0 -> no grants, mem_we=0, rvalids 0 the next cycle, `run_cnt` holds.
